// File: rtl/cpu_pkg.sv
// Shared definitions for the 301 processor datapath: widths and ALU opcodes.
package cpu_pkg;

   localparam int CPU_DW = 16;   // processor data width
   localparam int CPU_AW = 3;    // register-address width

   localparam logic [3:0] ALU_PASS_R = 4'h0;
   localparam logic [3:0] ALU_PASS_S = 4'h1;
   localparam logic [3:0] ALU_ADD    = 4'h2;
   localparam logic [3:0] ALU_SUB    = 4'h3;
   localparam logic [3:0] ALU_INC    = 4'h4;
   localparam logic [3:0] ALU_DEC    = 4'h5;
   localparam logic [3:0] ALU_SHL    = 4'h6;
   localparam logic [3:0] ALU_SHR    = 4'h7;
   localparam logic [3:0] ALU_AND    = 4'h8;
   localparam logic [3:0] ALU_OR     = 4'h9;
   localparam logic [3:0] ALU_XOR    = 4'hA;
   localparam logic [3:0] ALU_NOT    = 4'hB;

endpackage

// File: rtl/reg_file.sv
// Register file: NREG x DW, asynchronous clear, one synchronous write port,
// two combinational read ports with no write-to-read bypass.
module reg_file
   import cpu_pkg::*;
#(
   parameter int DW   = CPU_DW,
   parameter int NREG = 8,
   parameter int AW   = CPU_AW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr_a,
   input  logic [AW-1:0] raddr_b,
   output logic [DW-1:0] rdata_a,
   output logic [DW-1:0] rdata_b
);

   logic [DW-1:0] regs [NREG];

   // Storage: reset clears every register at once; otherwise write on the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   // Both read ports see the stored value; a same-cycle write lands at the edge.
   always_comb begin
      rdata_a = regs[raddr_a];
      rdata_b = regs[raddr_b];
   end

endmodule

// File: rtl/cpu_execution_unit.sv
// Execution unit: register file, S-operand mux and a 16-bit ALU with
// combinational N/Z/C flags. Flag capture is left to the control unit.
module cpu_execution_unit
   import cpu_pkg::*;
#(
   parameter int DW   = CPU_DW,
   parameter int NREG = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CPU_AW-1:0] W_Adr,
   input  logic [CPU_AW-1:0] R_Adr,
   input  logic [CPU_AW-1:0] S_Adr,
   input  logic              s_sel,
   input  logic              rw_en,
   input  logic [3:0]        alu_op,
   input  logic [DW-1:0]     DS,
   output logic [DW-1:0]     Reg_Out,
   output logic [DW-1:0]     Alu_Out,
   output logic              N,
   output logic              Z,
   output logic              C
);

   logic [DW-1:0] r_val;
   logic [DW-1:0] rf_s_val;
   logic [DW-1:0] s_val;
   logic [DW:0]   wide;   // bit DW carries carry/borrow/shift-out

   reg_file #(.DW(DW), .NREG(NREG), .AW(CPU_AW)) u_reg_file (
      .clk     (clk),
      .reset   (reset),
      .we      (rw_en),
      .waddr   (W_Adr),
      .wdata   (Alu_Out),
      .raddr_a (R_Adr),
      .raddr_b (S_Adr),
      .rdata_a (r_val),
      .rdata_b (rf_s_val)
   );

   // S operand comes from memory data when s_sel is set, else from the file.
   always_comb begin
      s_val = s_sel ? DS : rf_s_val;
   end

   // ALU evaluated at DW+1 bits so the top bit is the carry/borrow flag.
   always_comb begin
      wide = '0;
      case (alu_op)
         ALU_PASS_R: wide = {1'b0, r_val};
         ALU_PASS_S: wide = {1'b0, s_val};
         ALU_ADD:    wide = {1'b0, r_val} + {1'b0, s_val};
         ALU_SUB:    wide = {1'b0, r_val} - {1'b0, s_val};
         ALU_INC:    wide = {1'b0, s_val} + {{DW{1'b0}}, 1'b1};
         ALU_DEC:    wide = {1'b0, s_val} - {{DW{1'b0}}, 1'b1};
         ALU_SHL:    wide = {s_val, 1'b0};
         ALU_SHR:    wide = {s_val[0], 1'b0, s_val[DW-1:1]};
         ALU_AND:    wide = {1'b0, r_val & s_val};
         ALU_OR:     wide = {1'b0, r_val | s_val};
         ALU_XOR:    wide = {1'b0, r_val ^ s_val};
         ALU_NOT:    wide = {1'b0, ~s_val};
         default:    wide = '0;
      endcase
   end

   // Outputs and flags are pure functions of the inputs and register state.
   always_comb begin
      Reg_Out = r_val;
      Alu_Out = wide[DW-1:0];
      C       = wide[DW];
      N       = wide[DW-1];
      Z       = ~|wide[DW-1:0];
   end

endmodule

// File: tb/tb_cpu_execution_unit.sv
// Self-checking bench for cpu_execution_unit: directed steps from the test
// plan followed by random transactions checked against an arithmetic model.
module tb_cpu_execution_unit;

   logic        clk;
   logic        reset;
   logic [2:0]  W_Adr;
   logic [2:0]  R_Adr;
   logic [2:0]  S_Adr;
   logic        s_sel;
   logic        rw_en;
   logic [3:0]  alu_op;
   logic [15:0] DS;
   logic [15:0] Reg_Out;
   logic [15:0] Alu_Out;
   logic        N;
   logic        Z;
   logic        C;

   int tests;
   int fails;
   int mrf [8];   // reference register contents

   cpu_execution_unit dut (
      .clk     (clk),
      .reset   (reset),
      .W_Adr   (W_Adr),
      .R_Adr   (R_Adr),
      .S_Adr   (S_Adr),
      .s_sel   (s_sel),
      .rw_en   (rw_en),
      .alu_op  (alu_op),
      .DS      (DS),
      .Reg_Out (Reg_Out),
      .Alu_Out (Alu_Out),
      .N       (N),
      .Z       (Z),
      .C       (C)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU written with plain integer arithmetic.
   function automatic void ref_alu(input int op, input int r, input int s,
                                   output int res, output bit c);
      res = 0;
      c   = 1'b0;
      case (op)
         0:  res = r;
         1:  res = s;
         2:  begin res = (r + s) % 65536; c = (r + s) > 65535; end
         3:  begin res = (r - s + 65536) % 65536; c = (r < s); end
         4:  begin res = (s + 1) % 65536; c = (s == 65535); end
         5:  begin res = (s + 65535) % 65536; c = (s == 0); end
         6:  begin res = (s * 2) % 65536; c = (s >= 32768); end
         7:  begin res = s / 2; c = (s % 2) == 1; end
         8:  res = r & s;
         9:  res = r | s;
         10: res = r ^ s;
         11: res = 65535 - s;
         default: res = 0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input int w, input int ra, input int sa, input bit ss,
                         input bit we, input int op, input int ds);
      W_Adr  = 3'(w);
      R_Adr  = 3'(ra);
      S_Adr  = 3'(sa);
      s_sel  = ss;
      rw_en  = we;
      alu_op = 4'(op);
      DS     = 16'(ds);
      #1;
   endtask

   // Compare all outputs with what the model predicts for the current inputs.
   task automatic check_model(input string tag);
      int r, s, res;
      bit c;
      r = mrf[R_Adr];
      s = s_sel ? int'(DS) : mrf[S_Adr];
      ref_alu(int'(alu_op), r, s, res, c);
      chk({tag, ".reg"}, Reg_Out, 16'(r));
      chk({tag, ".alu"}, Alu_Out, 16'(res));
      chk({tag, ".n"}, {15'd0, N}, {15'd0, res >= 32768});
      chk({tag, ".z"}, {15'd0, Z}, {15'd0, res == 0});
      chk({tag, ".c"}, {15'd0, C}, {15'd0, c});
   endtask

   // Advance one clock edge and apply the expected write to the model.
   task automatic tick();
      int r, s, res, w;
      bit c, we;
      r  = mrf[R_Adr];
      s  = s_sel ? int'(DS) : mrf[S_Adr];
      ref_alu(int'(alu_op), r, s, res, c);
      we = rw_en && !reset;
      w  = int'(W_Adr);
      @(posedge clk);
      #1;
      if (we) mrf[w] = res;
   endtask

   task automatic load(input int idx, input int val);
      set_in(idx, idx, 0, 1'b1, 1'b1, 1, val);
      tick();
      $display("[TB] load R%0d <= %h", idx, val[15:0]);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      foreach (mrf[i]) mrf[i] = 0;
      reset = 1'b1;
      set_in(0, 0, 0, 1'b0, 1'b0, 0, 0);

      // Reset state with all inputs low.
      chk("rst.reg", Reg_Out, 16'h0000);
      chk("rst.alu", Alu_Out, 16'h0000);
      chk("rst.z", {15'd0, Z}, 16'h0001);
      chk("rst.n", {15'd0, N}, 16'h0000);
      chk("rst.c", {15'd0, C}, 16'h0000);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Fill the file with 0xAAAA, then reset asynchronously with a write pending.
      for (int i = 0; i < 8; i++) load(i, 16'hAAAA);
      set_in(0, 5, 0, 1'b0, 1'b0, 0, 0);
      chk("fill.r5", Reg_Out, 16'hAAAA);
      set_in(2, 0, 0, 1'b1, 1'b1, 1, 16'h5555);
      reset = 1'b1;
      #1;
      foreach (mrf[i]) mrf[i] = 0;
      for (int i = 0; i < 8; i++) begin
         R_Adr = 3'(i);
         #1;
         chk($sformatf("rstclr.r%0d", i), Reg_Out, 16'h0000);
      end
      tick();
      set_in(2, 2, 0, 1'b1, 1'b1, 1, 16'h5555);
      chk("rstwins.r2", Reg_Out, 16'h0000);
      chk("rstwins.z", {15'd0, Z}, 16'h0000);
      set_in(0, 0, 0, 1'b0, 1'b0, 0, 0);
      chk("rst.z_op0", {15'd0, Z}, 16'h0001);
      reset = 1'b0;
      $display("[TB] async reset clears file");

      // Write and readback; a disabled write leaves the register alone.
      load(1, 16'h1234);
      set_in(0, 1, 0, 1'b0, 1'b0, 0, 0);
      chk("wr.r1", Reg_Out, 16'h1234);
      set_in(1, 1, 0, 1'b1, 1'b0, 1, 16'hBEEF);
      tick();
      chk("nowr.r1", Reg_Out, 16'h1234);

      // Add overflow, then write the result.
      load(1, 16'hFFFF);
      load(2, 16'h0001);
      set_in(3, 1, 2, 1'b0, 1'b1, 2, 0);
      chk("add.alu", Alu_Out, 16'h0000);
      chk("add.z", {15'd0, Z}, 16'h0001);
      chk("add.c", {15'd0, C}, 16'h0001);
      chk("add.n", {15'd0, N}, 16'h0000);
      tick();
      set_in(0, 3, 0, 1'b0, 1'b0, 0, 0);
      chk("add.r3", Reg_Out, 16'h0000);

      // Subtract with and without borrow.
      load(1, 16'h0003);
      load(2, 16'h0005);
      set_in(0, 1, 2, 1'b0, 1'b0, 3, 0);
      chk("sub.alu", Alu_Out, 16'hFFFE);
      chk("sub.n", {15'd0, N}, 16'h0001);
      chk("sub.c", {15'd0, C}, 16'h0001);
      set_in(0, 2, 1, 1'b0, 1'b0, 3, 0);
      chk("subsw.alu", Alu_Out, 16'h0002);
      chk("subsw.c", {15'd0, C}, 16'h0000);

      // Shifts out of both ends; wrap of dec and inc.
      set_in(0, 0, 0, 1'b1, 1'b0, 6, 16'h8001);
      chk("shl.alu", Alu_Out, 16'h0002);
      chk("shl.c", {15'd0, C}, 16'h0001);
      set_in(0, 0, 0, 1'b1, 1'b0, 7, 16'h8001);
      chk("shr.alu", Alu_Out, 16'h4000);
      chk("shr.c", {15'd0, C}, 16'h0001);
      set_in(0, 0, 0, 1'b1, 1'b0, 5, 16'h0000);
      chk("dec.alu", Alu_Out, 16'hFFFF);
      chk("dec.c", {15'd0, C}, 16'h0001);
      set_in(0, 0, 0, 1'b1, 1'b0, 4, 16'hFFFF);
      chk("inc.alu", Alu_Out, 16'h0000);
      chk("inc.c", {15'd0, C}, 16'h0001);
      set_in(0, 0, 0, 1'b1, 1'b0, 13, 16'h1234);
      chk("rsvd.alu", Alu_Out, 16'h0000);
      $display("[TB] directed ALU cases done");

      // Read-during-write on R4, then asynchronous reset mid-cycle.
      load(4, 16'h0010);
      set_in(4, 4, 4, 1'b0, 1'b1, 4, 0);
      chk("rdw.before", Reg_Out, 16'h0010);
      chk("rdw.alu", Alu_Out, 16'h0011);
      tick();
      chk("rdw.after", Reg_Out, 16'h0011);
      rw_en = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("midrst.r4", Reg_Out, 16'h0000);
      foreach (mrf[i]) mrf[i] = 0;
      tick();
      reset = 1'b0;
      set_in(4, 4, 0, 1'b1, 1'b1, 1, 16'h0077);
      tick();
      chk("postrst.r4", Reg_Out, 16'h0077);
      $display("[TB] read-during-write and mid-cycle reset done");

      // Random transactions against the model.
      for (int t = 0; t < 400; t++) begin
         set_in($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                $urandom_range(0, 15), $urandom_range(0, 65535));
         check_model($sformatf("rnd%0d", t));
         $display("[TB] rnd%0d op=%h W=%0d R=%0d S=%0d ssel=%0b we=%0b DS=%h -> %h NZC=%0b%0b%0b",
                  t, alu_op, W_Adr, R_Adr, S_Adr, s_sel, rw_en, DS, Alu_Out, N, Z, C);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cpu_execution_unit.md
# cpu_execution_unit

Datapath execution unit of the 301 16-bit RISC processor: an 8×16 register file, an S-operand select mux and a 16-bit ALU. It sits directly downstream of the control unit and consumes its per-state control word: `W_Adr`, `R_Adr`, `S_Adr`, `s_sel`, `rw_en`, `alu_op`. It returns the combinational N/Z/C flags, which the control unit latches. It also drives the memory address path (`Reg_Out`) and the memory/write-back data path (`Alu_Out`).

## Interface
Parameters:
- `DW`, 16: data width; the whole processor assumes 16.
- `NREG`, 8: register count; addressed by 3-bit fields.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: asynchronous, active-high; clears the register file.
- `W_Adr`, input, 3: write register index.
- `R_Adr`, input, 3: R-operand read index.
- `S_Adr`, input, 3: S-operand read index.
- `s_sel`, input, 1: 0 selects S = RF[S_Adr]; 1 selects S = DS.
- `rw_en`, input, 1: register-file write enable.
- `alu_op`, input, 4: ALU function select.
- `DS`, input, 16: memory read data (LD, LDI).
- `Reg_Out`, output, 16: RF[R_Adr]; used as the memory address and the JMP target.
- `Alu_Out`, output, 16: ALU result; used as write-back data and memory write data.
- `N`, output, 1: equals `Alu_Out[15]`.
- `Z`, output, 1: high when `Alu_Out` == 0.
- `C`, output, 1: carry/borrow/shift-out, per the table in Operation.

## Operation
- R = RF[R_Adr]; S = s_sel ? DS : RF[S_Adr]. Both read ports are combinational.
- alu_op encoding:
  - 0: R (pass R)
  - 1: S (pass S)
  - 2: R+S
  - 3: R−S
  - 4: S+1
  - 5: S−1
  - 6: S<<1
  - 7: S>>1 (logical)
  - 8: R&S
  - 9: R|S
  - A: R^S
  - B: ~S
  - C–F: reserved; output 0, C=0.
- Carry rules, computed at 17 bits:
  - add/inc: C = bit 16 of the sum.
  - sub/dec: C = borrow, i.e. 1 when the minuend < subtrahend unsigned (R<S, or S==0 for dec).
  - shl: C = S[15]. shr: C = S[0].
  - pass and logic ops: C = 0.
- Results wrap modulo 2^16: 0xFFFF+1 = 0x0000 with C=1; 0x0000−1 = 0xFFFF with C=1.
- Write: on posedge clk with rw_en=1, RF[W_Adr] ← Alu_Out. With rw_en=0 the file holds. Every register, including R0 and R7, is general-purpose and writable.
- Flags are combinational only. This block has no flag register; the control unit decides when flags are captured, e.g. CMP captures them with rw_en=0.

## Timing
- Reset (asynchronous assert) clears all 8 registers to 0x0000 immediately. While reset is high, writes are ignored.
- Outputs after reset with inputs at 0: Reg_Out=0x0000, Alu_Out=0x0000, N=0, Z=1, C=0. The outputs remain pure functions of inputs and register state.
- Read latency is 0 cycles (combinational).
- Write latency is 1 cycle: the value is visible on the read ports after the capturing edge.
- Read-during-write to the same index returns the old value until the edge; there is no bypass.
- Same-register source and destination (e.g. INC R3,R3) is legal: the old value is read, and the new value is written at the edge.
- Reset released mid-program: the next edge behaves normally.
- If reset asserts in the same cycle as rw_en=1, reset wins and the register is 0.
- Combinational path R_Adr/S_Adr/DS → Alu_Out → flags must close within one clock period.

## Structure
- Shared package `cpu_pkg`:
  - alu_op localparams (ALU_PASS_R … ALU_NOT).
  - DW and register-address width.
- Sub-module `reg_file`: 8×16, asynchronous clear, one synchronous write port, two combinational read ports.
- The ALU and the S mux stay in the top module.

## Test plan
- **Reset:** assert reset with RF pre-written to 0xAAAA → all registers read 0x0000; Z=1 with alu_op=0.
- **Write/readback:** write R1=0x1234 via s_sel=1, DS=0x1234, alu_op=1, rw_en=1, W_Adr=1 → next cycle R_Adr=1 gives Reg_Out=0x1234. With rw_en=0, a second write attempt leaves it unchanged.
- **Add overflow:** R1=0xFFFF, R2=0x0001, alu_op=2 → Alu_Out=0x0000, Z=1, C=1, N=0. Write to R3 → R3=0x0000.
- **Sub/borrow:** R1=0x0003, R2=0x0005, alu_op=3 → Alu_Out=0xFFFE, N=1, C=1. Swapping operands gives 0x0002, C=0.
- **Shifts:** S=0x8001, alu_op=6 → 0x0002, C=1. alu_op=7 → 0x4000, C=1.
- **Read-during-write and async reset:** R4=0x0010, W_Adr=R_Adr=4, alu_op=4, rw_en=1 → Reg_Out=0x0010 before the edge and 0x0011 after. Reset pulsed mid-cycle → R4 becomes 0x0000 without waiting for a clock edge.
